keypad_scan: RTL and testbench



---
 rtl/keypad_scan.sv | 211 +++++++++++++++++++++
 tb/tb_keypad_scan.sv | 308 ++++++++++++++++++++++++++++++
 2 files changed

// File: rtl/keypad_scan.sv
// keypad_scan -- scanned 4x4 matrix keypad reader with debounce.
//
// Drives one keypad row low at a time, samples the (synchronized) columns
// once per scan tick and debounces presses and releases. Each accepted key
// is reported as row*4+col on key_code together with a one-cycle key_valid.
//
// Optional feature macro: KEYPAD_REPEAT_EN (auto-repeat while a key is held).
//
// Ports:
//   clk       in   system clock
//   rst       in   synchronous active-low reset
//   key_col   in   [3:0] column lines, asynchronous, low = pressed
//   key_row   out  [3:0] row drive, active-low, exactly one bit low
//   key_code  out  [3:0] last accepted key (row*4+col), held until next accept
//   key_valid out  one-cycle strobe when key_code is (re)issued
//   key_held  out  high while the accepted key is still pressed
//   dbg_state out  [1:0] FSM state (0=SCAN, 1=DEBOUNCE, 2=HELD)
//
// Output protocol: key_valid is a pure strobe with no back-pressure; the
// consumer must capture key_code in the cycle key_valid is high.
module keypad_scan #(
  parameter int SCAN_DIV       = 100000,
  parameter int DEBOUNCE_SCANS = 4,
  parameter int REPEAT_TICKS   = 32
) (
  input  logic       clk,
  input  logic       rst,
  input  logic [3:0] key_col,
  output logic [3:0] key_row,
  output logic [3:0] key_code,
  output logic       key_valid,
  output logic       key_held,
  output logic [1:0] dbg_state
);

  localparam int CW = $clog2(SCAN_DIV);
  localparam int MW = $clog2(DEBOUNCE_SCANS + 1);

  typedef enum logic [1:0] {
    ST_SCAN     = 2'd0,
    ST_DEBOUNCE = 2'd1,
    ST_HELD     = 2'd2
  } state_e;

  state_e          state_q, state_d;
  logic [3:0]      col_meta_q, col_s_q;
  logic [CW-1:0]   count_q;
  logic [1:0]      row_q, row_d;
  logic [1:0]      col_q, col_d;
  logic [MW-1:0]   m_q, m_d, m_inc;
  logic [3:0]      code_q, code_d;
  logic            valid_q, valid_d;
  logic            held_q, held_d;
  logic            tick;
  logic            any_low;
  logic [1:0]      sel_col;

`ifdef KEYPAD_REPEAT_EN
  localparam int RW = $clog2(2 * REPEAT_TICKS + 1);
  logic [RW-1:0]   rep_q, rep_d, rep_inc, rep_thr;
  logic            first_q, first_d;
`else
  logic            unused_repeat;
  assign unused_repeat = ^REPEAT_TICKS;
`endif

  assign tick    = (count_q == CW'(SCAN_DIV - 1));
  assign any_low = ~&col_s_q;
  assign m_inc   = m_q + MW'(1);

  // Lowest-index low column wins when several keys share the driven row.
  always_comb begin
    sel_col = 2'd0;
    for (int i = 3; i >= 0; i--) begin
      if (!col_s_q[i]) sel_col = 2'(i);
    end
  end

`ifdef KEYPAD_REPEAT_EN
  assign rep_inc = rep_q + RW'(1);
  // First repeat waits twice as long as the following ones.
  assign rep_thr = first_q ? RW'(2 * REPEAT_TICKS) : RW'(REPEAT_TICKS);
`endif

  always_comb begin
    state_d = state_q;
    row_d   = row_q;
    col_d   = col_q;
    m_d     = m_q;
    code_d  = code_q;
    valid_d = 1'b0;
    held_d  = held_q;
`ifdef KEYPAD_REPEAT_EN
    rep_d   = rep_q;
    first_d = first_q;
`endif
    if (tick) begin
      case (state_q)
        ST_SCAN: begin
          if (any_low) begin
            col_d = sel_col;
            if (DEBOUNCE_SCANS == 1) begin
              // Single-scan debounce: the capture tick is also the accept tick.
              code_d  = {row_q, sel_col};
              valid_d = 1'b1;
              held_d  = 1'b1;
              m_d     = '0;
              state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_d   = '0;
              first_d = 1'b1;
`endif
            end else begin
              m_d     = MW'(1);
              state_d = ST_DEBOUNCE;
            end
          end else begin
            row_d = row_q + 2'd1;
          end
        end
        ST_DEBOUNCE: begin
          if (any_low && (sel_col == col_q)) begin
            m_d = m_inc;
            if (m_inc == MW'(DEBOUNCE_SCANS)) begin
              code_d  = {row_q, col_q};
              valid_d = 1'b1;
              held_d  = 1'b1;
              m_d     = '0;
              state_d = ST_HELD;
`ifdef KEYPAD_REPEAT_EN
              rep_d   = '0;
              first_d = 1'b1;
`endif
            end
          end else begin
            m_d     = '0;
            state_d = ST_SCAN;
            row_d   = row_q + 2'd1;
          end
        end
        ST_HELD: begin
          if (!any_low) begin
            m_d = m_inc;
`ifdef KEYPAD_REPEAT_EN
            rep_d = '0;
`endif
            if (m_inc == MW'(DEBOUNCE_SCANS)) begin
              held_d  = 1'b0;
              m_d     = '0;
              state_d = ST_SCAN;
              row_d   = row_q + 2'd1;
            end
          end else begin
            // Any low column during release restarts the release count.
            m_d = '0;
`ifdef KEYPAD_REPEAT_EN
            rep_d = rep_inc;
            if (rep_inc == rep_thr) begin
              valid_d = 1'b1;
              rep_d   = '0;
              first_d = 1'b0;
            end
`endif
          end
        end
        default: state_d = ST_SCAN;
      endcase
    end
  end

  always_ff @(posedge clk) begin
    if (!rst) begin
      state_q    <= ST_SCAN;
      col_meta_q <= 4'hF;
      col_s_q    <= 4'hF;
      count_q    <= '0;
      row_q      <= 2'd0;
      col_q      <= 2'd0;
      m_q        <= '0;
      code_q     <= 4'd0;
      valid_q    <= 1'b0;
      held_q     <= 1'b0;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= '0;
      first_q    <= 1'b1;
`endif
    end else begin
      col_meta_q <= key_col;
      col_s_q    <= col_meta_q;
      count_q    <= tick ? '0 : count_q + CW'(1);
      state_q    <= state_d;
      row_q      <= row_d;
      col_q      <= col_d;
      m_q        <= m_d;
      code_q     <= code_d;
      valid_q    <= valid_d;
      held_q     <= held_d;
`ifdef KEYPAD_REPEAT_EN
      rep_q      <= rep_d;
      first_q    <= first_d;
`endif
    end
  end

  assign key_row   = ~(4'b0001 << row_q);
  assign key_code  = code_q;
  assign key_valid = valid_q;
  assign key_held  = held_q;
  assign dbg_state = state_q;

endmodule

// File: tb/tb_keypad_scan.sv
// Testbench for keypad_scan (SCAN_DIV=8, DEBOUNCE_SCANS=3, REPEAT_TICKS=4).
// A physical keypad model turns the pressed-key set and the driven row into
// column levels. A tick-level behavioural model predicts every output on every
// cycle; directed scenarios add hand-computed literal checks.
module tb_keypad_scan;
  localparam int SD = 8;
  localparam int DS = 3;
  localparam int RT = 4;

  logic       clk = 1'b0;
  logic       rst = 1'b0;
  logic [3:0] key_col;
  logic [3:0] key_row;
  logic [3:0] key_code;
  logic       key_valid;
  logic       key_held;
  logic [1:0] dbg_state;
  logic [15:0] pressed = '0;

  int total = 0;
  int bad   = 0;
  int valid_cnt = 0;
  logic [3:0] exp_q[$];

  keypad_scan #(.SCAN_DIV(SD), .DEBOUNCE_SCANS(DS), .REPEAT_TICKS(RT)) dut (
    .clk(clk), .rst(rst), .key_col(key_col), .key_row(key_row),
    .key_code(key_code), .key_valid(key_valid), .key_held(key_held),
    .dbg_state(dbg_state)
  );

  // ---------------- clock ----------------
  always #5 clk = ~clk;

  // ---------------- physical keypad ----------------
  always_comb begin
    key_col = 4'hF;
    for (int i = 0; i < 4; i++)
      for (int j = 0; j < 4; j++)
        if (key_row[i] === 1'b0 && pressed[i*4+j]) key_col[j] = 1'b0;
  end

  // ---------------- behavioural model ----------------
  // Outputs the DUT should show after the next rising edge.
  bit         m_live = 0;
  int         m_count, m_row, m_cand, m_agree, m_quiet, m_rep, m_reps;
  bit         m_holding;
  logic [3:0] m_s1, m_s2;
  logic [3:0] e_code;
  bit         e_valid;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    total++;
    if (act !== exp) begin
      bad++;
      $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
    end
  endtask

  task automatic accept_key();
    e_code    = 4'(m_row * 4 + m_cand);
    e_valid   = 1;
    m_holding = 1;
    m_cand    = -1;
    m_agree   = 0;
    m_quiet   = 0;
    m_rep     = 0;
    m_reps    = 0;
    exp_q.push_back(e_code);
  endtask

  task automatic model_step();
    logic [3:0] cs;
    bit tick, low;
    int first;
    e_valid = 0;
    if (rst === 1'b0) begin
      m_count = 0; m_row = 0; m_cand = -1; m_agree = 0; m_quiet = 0;
      m_rep = 0; m_reps = 0; m_holding = 0; e_code = 4'd0;
      m_s1 = 4'hF; m_s2 = 4'hF; m_live = 1;
      return;
    end
    if (!m_live) return;
    cs   = m_s2;
    tick = (m_count == SD - 1);
    m_s2 = m_s1;
    m_s1 = key_col;
    m_count = (m_count + 1) % SD;
    if (!tick) return;
    low = (cs != 4'hF);
    first = -1;
    for (int j = 3; j >= 0; j--) if (!cs[j]) first = j;
    if (m_holding) begin
      if (!low) begin
        m_quiet++;
        if (m_quiet == DS) begin
          m_holding = 0;
          m_quiet = 0;
          m_row = (m_row + 1) % 4;
        end
      end else begin
        m_quiet = 0;
      end
`ifdef KEYPAD_REPEAT_EN
      if (m_holding && low) begin
        m_rep++;
        if (m_rep == ((m_reps == 0) ? 2 * RT : RT)) begin
          m_rep = 0;
          m_reps++;
          e_valid = 1;
          exp_q.push_back(e_code);
        end
      end else begin
        m_rep = 0;
      end
`endif
    end else if (m_cand < 0) begin
      if (low) begin
        m_cand = first;
        m_agree = 1;
        if (m_agree == DS) accept_key();
      end else begin
        m_row = (m_row + 1) % 4;
      end
    end else begin
      if (low && first == m_cand) begin
        m_agree++;
        if (m_agree == DS) accept_key();
      end else begin
        m_cand = -1;
        m_agree = 0;
        m_row = (m_row + 1) % 4;
      end
    end
  endtask

  // ---------------- compare / scoreboard ----------------
  always @(negedge clk) begin
    if (m_live) begin
      check("key_row",   key_row,   4'hF ^ (4'h1 << m_row));
      check("key_code",  key_code,  e_code);
      check("key_valid", key_valid, e_valid);
      check("key_held",  key_held,  m_holding);
    end
    if (key_valid === 1'b1) begin
      valid_cnt++;
      if (exp_q.size() == 0) begin
        check("sb_unexpected_valid", 1, 0);
      end else begin
        check("sb_code", key_code, exp_q.pop_front());
      end
    end
    model_step();
  end

  // ---------------- driver tasks ----------------
  task automatic cycles(input int n);
    repeat (n) @(posedge clk);
    #1;
  endtask

  task automatic wait_held(input logic val, input int limit, input string name);
    int n = 0;
    while (key_held !== val && n < limit) begin
      cycles(1);
      n++;
    end
    check(name, key_held, val);
  endtask

  task automatic wait_row(input logic [3:0] row, input int limit);
    int n = 0;
    while (key_row !== row && n < limit) begin
      cycles(1);
      n++;
    end
    check("wait_row", key_row, row);
  endtask

  // ---------------- stimulus ----------------
  initial begin
    int base;
    int n;
    logic [3:0] row_seq [5];
    row_seq[0] = 4'b1110; row_seq[1] = 4'b1101; row_seq[2] = 4'b1011;
    row_seq[3] = 4'b0111; row_seq[4] = 4'b1110;

    // Reset held for two edges.
    cycles(2);
    check("rst_row",   key_row,   4'b1110);
    check("rst_code",  key_code,  4'd0);
    check("rst_valid", key_valid, 1'b0);
    check("rst_held",  key_held,  1'b0);
    rst = 1'b1;

    // Idle scan: 8 clocks per row.
    cycles(7);
    check("idle_row_hold", key_row, row_seq[0]);
    cycles(1);
    check("idle_row1", key_row, row_seq[1]);
    for (int i = 2; i < 5; i++) begin
      cycles(8);
      check("idle_row_seq", key_row, row_seq[i]);
    end

    // Clean press: row 2, col 1.
    base = valid_cnt;
    pressed[9] = 1'b1;
    cycles(200);
    check("clean_held", key_held, 1'b1);
    check("clean_row",  key_row,  4'b1011);
    check("clean_code", key_code, 4'd9);
`ifndef KEYPAD_REPEAT_EN
    check("clean_pulses", valid_cnt - base, 1);
`endif
    pressed[9] = 1'b0;
    wait_held(1'b0, 100, "clean_release");
    check("clean_resume_row3", key_row, 4'b0111);

    // Bounce: row 1, col 3 low for one tick, then stable.
    base = valid_cnt;
    wait_row(4'b1101, 100);
    pressed[7] = 1'b1;
    cycles(8);
    pressed[7] = 1'b0;
    cycles(30);
    check("bounce_no_valid", valid_cnt - base, 0);
    pressed[7] = 1'b1;
    wait_held(1'b1, 200, "bounce_accept");
    check("bounce_code", key_code, 4'd7);
    cycles(40);
    pressed[7] = 1'b0;
    wait_held(1'b0, 100, "bounce_release");
`ifndef KEYPAD_REPEAT_EN
    check("bounce_pulses", valid_cnt - base, 1);
`endif

    // Same-row multi-key, then a row-3 key during HELD.
    base = valid_cnt;
    pressed[0] = 1'b1;
    pressed[2] = 1'b1;
    wait_held(1'b1, 200, "multi_accept");
    check("multi_code", key_code, 4'd0);
    pressed[12] = 1'b1;
    cycles(100);
    check("multi_still_held", key_held, 1'b1);
    check("multi_code_kept", key_code, 4'd0);
`ifndef KEYPAD_REPEAT_EN
    check("multi_second_ignored", valid_cnt - base, 1);
`endif
    pressed[0] = 1'b0;
    pressed[2] = 1'b0;
    wait_held(1'b0, 100, "multi_release");
    wait_held(1'b1, 200, "row3_accept");
    check("row3_code", key_code, 4'd12);
    pressed[12] = 1'b0;
    wait_held(1'b0, 100, "row3_release");

    // Long hold row 3, col 3 (auto-repeat when enabled).
    base = valid_cnt;
    pressed[15] = 1'b1;
    wait_held(1'b1, 200, "long_accept");
    check("long_code", key_code, 4'd15);
    cycles(120 * SD);
    pressed[15] = 1'b0;
    wait_held(1'b0, 100, "long_release");
    n = valid_cnt - base;
`ifdef KEYPAD_REPEAT_EN
    check("long_repeats", (n >= 25), 1);
`else
    check("long_single_pulse", n, 1);
`endif
    cycles(80);
    check("long_quiet_after_release", valid_cnt - base, n);

    // Reset during the second matching tick.
    base = valid_cnt;
    pressed[5] = 1'b1;
    n = 0;
    while (m_cand < 0 && n < 200) begin
      cycles(1);
      n++;
    end
    check("mid_capture_seen", (m_cand >= 0), 1);
    cycles(7);
    rst = 1'b0;
    cycles(2);
    check("mid_rst_row",   key_row,   4'b1110);
    check("mid_rst_code",  key_code,  4'd0);
    check("mid_rst_valid", key_valid, 1'b0);
    check("mid_rst_held",  key_held,  1'b0);
    pressed[5] = 1'b0;
    rst = 1'b1;
    cycles(50);
    check("mid_no_valid", valid_cnt - base, 0);

    check("sb_drained", exp_q.size(), 0);
    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

  // Global time bound.
  initial begin
    #2000000;
    $display("FAIL global_timeout: got running expected finished");
    $fatal(1, "timeout");
  end

endmodule
